// File: rtl/div64_req_seq.sv
// div64_req_seq: request FIFO feeding one outstanding 64-bit divide at a time,
// with zero-divisor bypass, response tag check and a result watchdog.
module div64_req_seq #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 127
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_dividend,
  input  logic [63:0] req_divisor,
  input  logic [4:0]  req_tag,
  output logic        div_in_en,
  output logic [63:0] div_in1,
  output logic [63:0] div_in2,
  output logic [4:0]  div_in_usr,
  input  logic        div_out_en,
  input  logic [63:0] div_quotient,
  input  logic [63:0] div_remainder,
  input  logic [4:0]  div_out_usr,
  input  logic        div_dbz,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_quotient,
  output logic [63:0] resp_remainder,
  output logic [4:0]  resp_tag,
  output logic        resp_dbz,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD
  } state_t;

  state_t state, state_nx;

  logic [63:0]   mem_a [DEPTH];
  logic [63:0]   mem_b [DEPTH];
  logic [4:0]    mem_t [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  logic [63:0]   op_a, op_b;
  logic [4:0]    op_t;
  logic [WW-1:0] wd;

  logic push, pop, zdiv, take, expire, time_up;

  assign req_ready = reset && (count < FULL);
  assign push      = req_valid && req_ready;
  assign pop       = (state == IDLE) && (count != '0);
  assign zdiv      = (mem_b[rd_ptr] == 64'd0);
  assign time_up   = (wd == WD_LAST);
  assign take      = (state == WAIT) && div_out_en;
  assign expire    = (state == WAIT) && !div_out_en && time_up;

  assign div_in_en  = (state == ISSUE);
  assign div_in1    = op_a;
  assign div_in2    = op_b;
  assign div_in_usr = op_t;
  assign resp_valid = (state == HOLD);

  always_ff @(posedge clock) begin
    if (push) begin
      mem_a[wr_ptr] <= req_dividend;
      mem_b[wr_ptr] <= req_divisor;
      mem_t[wr_ptr] <= req_tag;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (pop) state_nx = zdiv ? HOLD : ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (div_out_en || time_up) state_nx = HOLD;
      HOLD:    if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_a           <= '0;
      op_b           <= '0;
      op_t           <= '0;
      wd             <= '0;
      resp_quotient  <= '0;
      resp_remainder <= '0;
      resp_tag       <= '0;
      resp_dbz       <= 1'b0;
      resp_err       <= 1'b0;
    end else begin
      if (pop) begin
        op_a <= mem_a[rd_ptr];
        op_b <= mem_b[rd_ptr];
        op_t <= mem_t[rd_ptr];
      end
      if (state == ISSUE)     wd <= '0;
      else if (state == WAIT) wd <= wd + 1'b1;
      // zero divisor never reaches the divider
      if (pop && zdiv) begin
        resp_quotient  <= '1;
        resp_remainder <= mem_a[rd_ptr];
        resp_tag       <= mem_t[rd_ptr];
        resp_dbz       <= 1'b1;
        resp_err       <= 1'b0;
      end else if (take) begin
        resp_quotient  <= div_quotient;
        resp_remainder <= div_remainder;
        resp_tag       <= div_out_usr;
        resp_dbz       <= div_dbz;
        resp_err       <= (div_out_usr != op_t);
      end else if (expire) begin
        resp_quotient  <= '0;
        resp_remainder <= '0;
        resp_tag       <= op_t;
        resp_dbz       <= 1'b0;
        resp_err       <= 1'b1;
      end
    end
  end

endmodule
